// File: rtl/signext_arb_pkg.sv
// rtl/signext_arb_pkg.sv - shared widths, types and opcode fields for the signext arbiter
package signext_arb_pkg;

    localparam int INSTR_W = 32;
    localparam int IMM_W   = 64;
    localparam int STAT_W  = 32;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [IMM_W-1:0]   imm_t;

    // Opcode fields recognised by signext
    localparam logic [10:0] OP_LDUR   = 11'h7C2;
    localparam logic [10:0] OP_STUR   = 11'h7C0;
    localparam logic [6:0]  OP_CBZ_NZ = 7'b1011010;
    localparam logic [7:0]  OP_BCOND  = 8'h54;
    localparam logic [5:0]  OP_B      = 6'b000101;

endpackage

// File: rtl/signext.sv
// rtl/signext.sv - combinational immediate sign extender for D, CB and B instruction formats
module signext
    import signext_arb_pkg::*;
(
    input  instr_t inst,
    output imm_t   imm
);

    // Pick the immediate field by opcode; formats without an immediate give zero
    always_comb begin
        imm = '0;
        if (inst[31:21] == OP_LDUR || inst[31:21] == OP_STUR) begin
            imm = {{55{inst[20]}}, inst[20:12]};
        end else if (inst[31:25] == OP_CBZ_NZ || inst[31:24] == OP_BCOND) begin
            imm = {{45{inst[23]}}, inst[23:5]};
        end else if (inst[31:26] == OP_B) begin
            imm = {{38{inst[25]}}, inst[25:0]};
        end
    end

endmodule

// File: rtl/signext_arbiter_rr_arbiter.sv
// rtl/signext_arbiter_rr_arbiter.sv - round-robin search starting at a pointer, one-hot grant plus index
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  grant_idx_o,
    output logic             grant_any_o
);

    // Walk the requesters from ptr_i, wrapping modulo N_REQ; the first set bit wins
    always_comb begin
        int              sum;
        logic [ID_W-1:0] cand;
        logic            found;
        sum         = 0;
        cand        = '0;
        found       = 1'b0;
        grant_o     = '0;
        grant_idx_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = int'(ptr_i) + k;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            cand = ID_W'(sum);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
        grant_any_o = found;
    end

endmodule

// File: rtl/signext_arbiter.sv
// rtl/signext_arbiter.sv - round-robin shared signext with one registered result slot; SIGNEXT_ARB_STATS_EN adds counters
module signext_arbiter
    import signext_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [INSTR_W*N_REQ-1:0] req_instr,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [IMM_W-1:0]         resp_imm,
    output logic [ID_W-1:0]          resp_id
`ifdef SIGNEXT_ARB_STATS_EN
    ,
    output logic [STAT_W*N_REQ-1:0]  grant_cnt,
    output logic [STAT_W-1:0]        stall_cnt
`endif
);

    logic            resp_valid_q, resp_valid_d;
    imm_t            resp_imm_q, resp_imm_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  win_idx;
    logic             win_any;
    logic             can_accept;
    logic [N_REQ-1:0] accept_vec;
    logic             accept;
    instr_t           sel_instr;
    imm_t             sel_imm;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (win_idx),
        .grant_any_o (win_any)
    );

    // The slot can take a new result when it is empty or being drained this cycle
    always_comb begin
        can_accept = ~resp_valid_q | resp_ready;
        req_ready  = (reset && can_accept && win_any) ? grant : '0;
        accept_vec = req_valid & req_ready;
        accept     = |accept_vec;
    end

    // Route the winning requester's instruction into the single signext
    always_comb begin
        sel_instr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                sel_instr = req_instr[INSTR_W*i +: INSTR_W];
            end
        end
    end

    signext u_signext (
        .inst (sel_instr),
        .imm  (sel_imm)
    );

    // Next slot contents: accept overwrites (even while draining), drain alone only clears valid
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_imm_d   = resp_imm_q;
        resp_id_d    = resp_id_q;
        ptr_d        = ptr_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_imm_d   = sel_imm;
            resp_id_d    = win_idx;
            ptr_d        = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // Result slot and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_q <= 1'b0;
            resp_imm_q   <= '0;
            resp_id_q    <= '0;
            ptr_q        <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_imm_q   <= resp_imm_d;
            resp_id_q    <= resp_id_d;
            ptr_q        <= ptr_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_imm   = resp_imm_q;
    assign resp_id    = resp_id_q;

`ifdef SIGNEXT_ARB_STATS_EN
    logic [STAT_W-1:0] grant_cnt_q [N_REQ];
    logic [STAT_W-1:0] stall_cnt_q;

    // Saturating per-requester accept counters and output-stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (accept_vec[i] && grant_cnt_q[i] != '1) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + STAT_W'(1);
                end
            end
            if (resp_valid_q && !resp_ready && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + STAT_W'(1);
            end
        end
    end

    // Flatten the counter array onto the output bus
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_cnt[STAT_W*i +: STAT_W] = grant_cnt_q[i];
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
